// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card SPI command sequencer.
// Frames are full 48-bit SPI command tokens including CRC and end bit.
package sd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_C0,
    S_C8,
    S_C55,
    S_A41,
    S_C58,
    S_C16,
    S_READY,
    S_C17,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_ERROR
  } sd_state_e;

  localparam logic [47:0] CMD0_FRAME  = 48'h40_00000000_95;
  localparam logic [47:0] CMD8_FRAME  = 48'h48_000001AA_87;
  localparam logic [47:0] CMD55_FRAME = 48'h77_00000000_65;
  localparam logic [47:0] CMD58_FRAME = 48'h7A_00000000_FD;
  localparam logic [47:0] CMD16_FRAME = 48'h50_00000200_15;
  localparam logic [7:0]  CMD17_CMD   = 8'h51;
  localparam logic [7:0]  CMD17_CRC   = 8'hFF;

  localparam logic [3:0] ERR_CMD0    = 4'd1;
  localparam logic [3:0] ERR_CMD8    = 4'd2;
  localparam logic [3:0] ERR_ACMD41  = 4'd3;
  localparam logic [3:0] ERR_R1      = 4'd4;
  localparam logic [3:0] ERR_TOKEN   = 4'd5;
  localparam logic [3:0] ERR_TIMEOUT = 4'd6;

  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] BYTE_IDLE   = 8'hFF;
  localparam logic [7:0] R1_IDLE     = 8'h01;
  localparam logic [7:0] R1_OK       = 8'h00;
  localparam logic [7:0] R1_V1       = 8'h05;

  function automatic logic [47:0] acmd41_frame(
    input logic v2
  );
    return {8'h69, (v2 ? 8'h40 : 8'h00), 24'h0, 8'h77};
  endfunction

endpackage

// File: rtl/sd_resp_collector.sv
// Gathers R1 (1 byte) or R3/R7 (5 byte) responses from the SPI engine.
// resp includes the byte being accepted so it is complete with resp_done.
module sd_resp_collector
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        len5,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        resp_done,
  output logic        resp_first,
  output logic [39:0] resp
);

  logic [39:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        take;

  assign take = en && byte_valid;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (take) begin
      sh_d  = {sh_q[31:0], byte_in};
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign resp       = {sh_q[31:0], byte_in};
  assign resp_first = (cnt_q == 3'd0);
  assign resp_done  = take &&
                      (cnt_q == (len5 ? 3'd4 : 3'd0));

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SPI-mode SD init sequence and single-block read controller.
// Drives 48-bit frames to the bit engine and checks every response.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int CMD0_RETRIES   = 8,
  parameter int ACMD41_RETRIES = 1000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        ready,
  output logic        busy,
  output logic        data_valid,
  output logic [7:0]  data_byte,
  output logic        rd_done,
  output logic        error,
  output logic [3:0]  err_code,
  output logic        sdhc,
  output logic [47:0] eng_cmd,
  output logic        eng_send,
  input  logic        eng_busy,
  input  logic        eng_byte_valid,
  input  logic [7:0]  eng_byte,
  output logic        eng_stop
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int C0W = $clog2(CMD0_RETRIES + 1);
  localparam int AW  = $clog2(ACMD41_RETRIES + 2);
  localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [C0W-1:0] C0_LAST  = C0W'(CMD0_RETRIES - 1);
  localparam logic [AW-1:0]  A41_MAX  = AW'(ACMD41_RETRIES);

  sd_state_e   state_q, state_d, nxt;
  logic        wait_q, wait_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [C0W-1:0] c0_q, c0_d;
  logic [AW-1:0]  a41_q, a41_d;
  logic [8:0]  dcnt_q, dcnt_d;
  logic        v2_q, v2_d, sdhc_q, sdhc_d;
  logic [31:0] addr_q, addr_d;
  logic [47:0] cmd_q, cmd_d, frame;
  logic        send_q, send_d, stop_q, stop_d;
  logic        dv_q, dv_d, done_q, done_d;
  logic [7:0]  db_q, db_d;
  logic        err_q, err_d;
  logic [3:0]  code_q, code_d, fail;

  logic        is_cmd, en, len5, early, done;
  logic        r_done, r_first, tmo_run, expire;
  logic [39:0] resp;
  logic [7:0]  r1;
  logic        unused_resp;

  sd_resp_collector u_coll (
    .clk        (clk),
    .rst        (rst),
    .clr        (send_d),
    .en         (en),
    .len5       (len5),
    .byte_valid (eng_byte_valid),
    .byte_in    (eng_byte),
    .resp_done  (r_done),
    .resp_first (r_first),
    .resp       (resp)
  );

  assign is_cmd = state_q inside {S_C0, S_C8, S_C55, S_A41,
                                  S_C58, S_C16, S_C17};
  assign en     = is_cmd && wait_q;
  assign len5   = (state_q == S_C8) || (state_q == S_C58);
  // A 5-byte wait ends early when R1 carries an error bit
  assign early  = en && eng_byte_valid && len5 && r_first &&
                  (eng_byte[7:1] != 7'd0);
  assign done   = r_done || early;
  assign r1     = (len5 && !early) ? resp[39:32] : eng_byte;
  assign tmo_run = en ||
                   (state_q inside {S_TOKEN, S_DATA, S_CRC});
  assign expire = tmo_run && !eng_byte_valid && (tmo_q == '0);
  assign unused_resp = ^{resp[31], resp[29:16]};

  always_comb begin
    unique case (state_q)
      S_C0:    frame = CMD0_FRAME;
      S_C8:    frame = CMD8_FRAME;
      S_C55:   frame = CMD55_FRAME;
      S_A41:   frame = acmd41_frame(v2_q);
      S_C58:   frame = CMD58_FRAME;
      S_C16:   frame = CMD16_FRAME;
      default: frame = {CMD17_CMD, addr_q, CMD17_CRC};
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    c0_d    = c0_q;
    a41_d   = a41_q;
    dcnt_d  = dcnt_q;
    v2_d    = v2_q;
    sdhc_d  = sdhc_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    send_d  = 1'b0;
    stop_d  = 1'b0;
    dv_d    = 1'b0;
    db_d    = db_q;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    nxt     = state_q;
    fail    = '0;
    if (tmo_run)
      tmo_d = eng_byte_valid ? TMO_LOAD : tmo_q - TW'(1);
    unique case (state_q)
      S_IDLE, S_ERROR: if (start) begin
        state_d = S_C0;
        wait_d  = 1'b0;
        c0_d    = '0;
        a41_d   = '0;
        v2_d    = 1'b0;
        sdhc_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = '0;
      end
      S_READY: if (rd_req) begin
        state_d = S_C17;
        wait_d  = 1'b0;
        addr_d  = sdhc_q ? rd_addr : {rd_addr[22:0], 9'd0};
      end
      S_TOKEN: begin
        if (eng_byte_valid) begin
          unique case (1'b1)
            (eng_byte == BYTE_IDLE): ;
            (eng_byte == TOKEN_START): begin
              state_d = S_DATA;
              dcnt_d  = '0;
            end
            default: fail = ERR_TOKEN;
          endcase
        end else if (expire) fail = ERR_TIMEOUT;
      end
      S_DATA: begin
        if (eng_byte_valid) begin
          dv_d   = 1'b1;
          db_d   = eng_byte;
          dcnt_d = dcnt_q + 9'd1;
          if (dcnt_q == 9'd511) state_d = S_CRC;
        end else if (expire) fail = ERR_TIMEOUT;
      end
      S_CRC: begin
        if (eng_byte_valid) begin
          dcnt_d = dcnt_q + 9'd1;
          if (dcnt_q[0]) begin
            state_d = S_READY;
            stop_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else if (expire) fail = ERR_TIMEOUT;
      end
      default: begin
        if (!wait_q) begin
          if (!eng_busy) begin
            send_d = 1'b1;
            wait_d = 1'b1;
            tmo_d  = TMO_LOAD;
            cmd_d  = frame;
          end
        end else if (done) begin
          stop_d = 1'b1;
          unique case (state_q)
            S_C0:
              if (r1 == R1_IDLE) nxt = S_C8;
              else if (c0_q == C0_LAST) fail = ERR_CMD0;
              else c0_d = c0_q + C0W'(1);
            S_C8:
              if (r1 == R1_IDLE && resp[15:0] == 16'h01AA) begin
                v2_d = 1'b1;
                nxt  = S_C55;
              end else if (r1 == R1_V1) begin
                v2_d = 1'b0;
                nxt  = S_C55;
              end else fail = ERR_CMD8;
            S_C55:
              if (r1 == R1_OK || r1 == R1_IDLE) nxt = S_A41;
              else fail = ERR_R1;
            S_A41:
              if (r1 == R1_OK) nxt = v2_q ? S_C58 : S_C16;
              else if (r1 != R1_IDLE) fail = ERR_R1;
              else if (a41_q == A41_MAX) fail = ERR_ACMD41;
              else begin
                a41_d = a41_q + AW'(1);
                nxt   = S_C55;
              end
            S_C58:
              if (r1 == R1_OK) begin
                sdhc_d = resp[30];
                nxt    = resp[30] ? S_READY : S_C16;
              end else fail = ERR_R1;
            S_C16:
              if (r1 == R1_OK) nxt = S_READY;
              else fail = ERR_R1;
            default:
              if (r1 == R1_OK) begin
                nxt    = S_TOKEN;
                stop_d = 1'b0;
                tmo_d  = TMO_LOAD;
              end else fail = ERR_R1;
          endcase
          state_d = nxt;
          wait_d  = 1'b0;
        end else if (expire) fail = ERR_TIMEOUT;
      end
    endcase
    if (fail != 4'd0) begin
      state_d = S_ERROR;
      wait_d  = 1'b0;
      stop_d  = 1'b1;
      err_d   = 1'b1;
      code_d  = fail;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      tmo_q   <= '0;
      c0_q    <= '0;
      a41_q   <= '0;
      dcnt_q  <= '0;
      v2_q    <= 1'b0;
      sdhc_q  <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '1;
      send_q  <= 1'b0;
      stop_q  <= 1'b0;
      dv_q    <= 1'b0;
      db_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      c0_q    <= c0_d;
      a41_q   <= a41_d;
      dcnt_q  <= dcnt_d;
      v2_q    <= v2_d;
      sdhc_q  <= sdhc_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      send_q  <= send_d;
      stop_q  <= stop_d;
      dv_q    <= dv_d;
      db_q    <= db_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign ready      = (state_q == S_READY);
  assign busy       = !(state_q inside {S_IDLE, S_READY, S_ERROR});
  assign data_valid = dv_q;
  assign data_byte  = db_q;
  assign rd_done    = done_q;
  assign error      = err_q;
  assign err_code   = code_q;
  assign sdhc       = sdhc_q;
  assign eng_cmd    = cmd_q;
  assign eng_send   = send_q;
  assign eng_stop   = stop_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer with a scripted SPI engine.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_sd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        eng_busy = 1'b0;
  logic        eng_byte_valid = 1'b0;
  logic [7:0]  eng_byte = '0;
  logic        ready, busy, data_valid, rd_done, error, sdhc;
  logic        eng_send, eng_stop;
  logic [7:0]  data_byte;
  logic [3:0]  err_code;
  logic [47:0] eng_cmd;

  int total = 0;
  int passed = 0;
  int nsend = 0, nstop = 0, ndone = 0, ndv = 0, nbad = 0;
  int s0, st0, d0, cnt;
  bit got;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(
    .CMD0_RETRIES   (8),
    .ACMD41_RETRIES (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .ready          (ready),
    .busy           (busy),
    .data_valid     (data_valid),
    .data_byte      (data_byte),
    .rd_done        (rd_done),
    .error          (error),
    .err_code       (err_code),
    .sdhc           (sdhc),
    .eng_cmd        (eng_cmd),
    .eng_send       (eng_send),
    .eng_busy       (eng_busy),
    .eng_byte_valid (eng_byte_valid),
    .eng_byte       (eng_byte),
    .eng_stop       (eng_stop)
  );

  always @(negedge clk) begin
    if (eng_send) nsend <= nsend + 1;
    if (eng_stop) nstop <= nstop + 1;
    if (rd_done)  ndone <= ndone + 1;
    if (data_valid) begin
      if (data_byte !== ndv[7:0]) nbad <= nbad + 1;
      ndv <= ndv + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_send(output bit g);
    g = 1'b0;
    for (int i = 0; i < 300 && !g; i++) begin
      @(negedge clk);
      if (eng_send) g = 1'b1;
    end
  endtask

  task automatic send_chk(input string tag, input logic [47:0] exp);
    bit g;
    wait_send(g);
    chk({tag, "_sent"}, 64'(g), 64'd1);
    if (g) chk(tag, 64'(eng_cmd), 64'(exp));
  endtask

  task automatic give(input logic [7:0] b);
    eng_byte = b;
    eng_byte_valid = 1'b1;
    @(negedge clk);
    eng_byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_rd(input logic [31:0] a);
    rd_addr = a;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 300 && !ready; i++) @(negedge clk);
    chk(tag, 64'(ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_flags", 64'({ready, busy, data_valid, rd_done,
                          error, sdhc, eng_send, eng_stop}), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_data_byte", 64'(data_byte), 64'd0);
    chk("rst_eng_cmd", 64'(eng_cmd), 64'hFFFF_FFFF_FFFF);
    rst = 1'b0;
    @(negedge clk);

    s0 = nsend;
    pulse_rd(32'd5);
    repeat (10) @(negedge clk);
    chk("idle_rdreq_nosend", 64'(nsend - s0), 64'd0);
    chk("idle_not_ready", 64'(ready), 64'd0);

    eng_busy = 1'b1;
    s0 = nsend;
    pulse_start();
    repeat (8) @(negedge clk);
    chk("engbusy_nosend", 64'(nsend - s0), 64'd0);
    chk("engbusy_busy_out", 64'(busy), 64'd1);
    eng_busy = 1'b0;
    send_chk("v2_cmd0", 48'h40_00000000_95);
    give(8'h01);
    send_chk("v2_cmd8", 48'h48_000001AA_87);
    give(8'h01); give(8'h00); give(8'h00); give(8'h01); give(8'hAA);
    for (int i = 0; i < 3; i++) begin
      send_chk("v2_cmd55", 48'h77_00000000_65);
      give(8'h01);
      send_chk("v2_acmd41", 48'h69_40000000_77);
      give(i < 2 ? 8'h01 : 8'h00);
    end
    send_chk("v2_cmd58", 48'h7A_00000000_FD);
    give(8'h00); give(8'hC0); give(8'hFF); give(8'h80); give(8'h00);
    wait_ready("v2_ready");
    @(negedge clk);
    chk("v2_sdhc", 64'(sdhc), 64'd1);
    chk("v2_no_cmd16", 64'(nsend - s0), 64'd9);
    chk("v2_not_busy", 64'(busy), 64'd0);

    s0 = nsend; st0 = nstop; d0 = ndone;
    pulse_rd(32'd7);
    send_chk("rd_cmd17", 48'h51_00000007_FF);
    give(8'h00); give(8'hFF); give(8'hFF); give(8'hFE);
    for (int i = 0; i < 512; i++) give(8'(i));
    give(8'h3C); give(8'h5A);
    repeat (3) @(negedge clk);
    chk("rd_dv_count", 64'(ndv), 64'd512);
    chk("rd_data_bad", 64'(nbad), 64'd0);
    chk("rd_done_count", 64'(ndone - d0), 64'd1);
    chk("rd_stop_count", 64'(nstop - st0), 64'd1);
    chk("rd_back_ready", 64'(ready), 64'd1);

    pulse_rd(32'd9);
    send_chk("rd2_cmd17", 48'h51_00000009_FF);
    give(8'h00); give(8'hFE);
    for (int i = 0; i < 10; i++) give(8'(i));
    chk("mid_data_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_flags", 64'({ready, busy, data_valid, rd_done,
                             error, sdhc, eng_send, eng_stop}), 64'd0);
    chk("midrst_data_byte", 64'(data_byte), 64'd0);
    chk("midrst_eng_cmd", 64'(eng_cmd), 64'hFFFF_FFFF_FFFF);
    rst = 1'b0;
    @(negedge clk);

    pulse_start();
    send_chk("v1_cmd0", 48'h40_00000000_95);
    give(8'h01);
    send_chk("v1_cmd8", 48'h48_000001AA_87);
    give(8'h05);
    send_chk("v1_cmd55", 48'h77_00000000_65);
    give(8'h01);
    send_chk("v1_acmd41", 48'h69_00000000_77);
    give(8'h00);
    send_chk("v1_cmd16", 48'h50_00000200_15);
    give(8'h00);
    wait_ready("v1_ready");
    chk("v1_sdhc", 64'(sdhc), 64'd0);
    pulse_rd(32'd3);
    send_chk("v1_cmd17", 48'h51_00000600_FF);
    give(8'h00); give(8'hFF); give(8'h05);
    chk("tok_error", 64'(error), 64'd1);
    chk("tok_code", 64'(err_code), 64'd5);

    pulse_start();
    send_chk("a41x_cmd0", 48'h40_00000000_95);
    give(8'h01);
    send_chk("a41x_cmd8", 48'h48_000001AA_87);
    give(8'h01); give(8'h00); give(8'h00); give(8'h01); give(8'hAA);
    for (int i = 0; i < 20 && !error; i++) begin
      wait_send(got);
      if (!got) break;
      give(8'h01);
    end
    chk("a41x_error", 64'(error), 64'd1);
    chk("a41x_code", 64'(err_code), 64'd3);
    pulse_start();
    chk("a41x_start_clears", 64'(error), 64'd0);
    send_chk("restart_cmd0", 48'h40_00000000_95);

    cnt = 1;
    give(8'hFF);
    for (int i = 0; i < 20 && !error; i++) begin
      wait_send(got);
      if (!got) break;
      cnt++;
      give(8'hFF);
    end
    chk("cmd0_sends", 64'(cnt), 64'd8);
    chk("cmd0_error", 64'(error), 64'd1);
    chk("cmd0_code", 64'(err_code), 64'd1);

    pulse_start();
    wait_send(got);
    chk("tmo_sent", 64'(got), 64'd1);
    repeat (99) @(negedge clk);
    chk("tmo_not_yet", 64'(error), 64'd0);
    @(negedge clk);
    chk("tmo_error", 64'(error), 64'd1);
    chk("tmo_code", 64'(err_code), 64'd6);
    chk("tmo_stop", 64'(eng_stop), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
